// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the fetch/decode path.
//   ADDR_WIDTH     : default address width in bits
//   JR_STACK_DEPTH : default number of return-address stack entries
//   RESET_PC       : value address registers take on reset
//   addr_t         : default-width address type
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int JR_STACK_DEPTH = 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t RESET_PC = '0;

endpackage

// File: rtl/jr_stack_mem.sv
// ---------------------------------------------------------------------------
// jr_stack_mem
// DEPTH x AW register array backing the return-address stack.
// Contents are not reset; the owner tracks which entries are meaningful.
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : combinational read index
//   rdata : combinational read data at raddr
// ---------------------------------------------------------------------------
module jr_stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] entries [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/jr_target_stack.sv
// ---------------------------------------------------------------------------
// jr_target_stack
// Return-address stack that predicts jump-register targets and checks the
// prediction against the resolved rs value, raising a registered one-cycle
// mispredict/redirect toward the PC-select logic.
//
// Optional feature: define JR_STACK_STATS_EN to add saturating hit_count and
// miss_count outputs (32 bits each).
//
// Ports:
//   clk           : system clock, all state on rising edge
//   reset         : synchronous, active-high reset
//   push_en       : JAL decoded this cycle
//   push_addr     : return address to push
//   pop_en        : JR decoded this cycle
//   actual_target : resolved rs value, valid with pop_en
//   flush         : suppresses the mispredict registered this cycle
//   pred_target   : combinational top of stack, 0 when empty
//   pred_valid    : combinational, stack non-empty
//   mispredict    : registered one-cycle miss pulse
//   redirect_pc   : registered correct target accompanying mispredict
//   hit_count     : (JR_STACK_STATS_EN) pops that matched
//   miss_count    : (JR_STACK_STATS_EN) pops that missed
// ---------------------------------------------------------------------------
module jr_target_stack
  import mips_pkg::*;
#(
  parameter int DEPTH = JR_STACK_DEPTH,
  parameter int AW    = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_en,
  input  logic [AW-1:0] push_addr,
  input  logic          pop_en,
  input  logic [AW-1:0] actual_target,
  input  logic          flush,
  output logic [AW-1:0] pred_target,
  output logic          pred_valid,
  output logic          mispredict,
  output logic [AW-1:0] redirect_pc
`ifdef JR_STACK_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] tos, tos_next;
  logic [CW-1:0] count, count_next;
  logic          we;
  logic [PW-1:0] waddr;
  logic [AW-1:0] top_entry;
  logic          empty;
  logic          full;
  logic          miss;

  jr_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (tos),
    .rdata (top_entry)
  );

  // A pop is always judged against the current top before any push in the
  // same cycle lands. A push+pop on a non-empty stack replaces the top in
  // place; on an empty stack it degenerates to a plain push. Pointer wrap
  // is free because DEPTH is a power of two.
  always_comb begin
    empty       = (count == '0);
    full        = (count == CW'(DEPTH));
    pred_valid  = !empty;
    pred_target = empty ? '0 : top_entry;
    miss        = pop_en && (empty || (top_entry != actual_target));

    tos_next    = tos;
    count_next  = count;
    we          = 1'b0;
    waddr       = tos + PW'(1);

    if (push_en && pop_en && !empty) begin
      we    = 1'b1;
      waddr = tos;
    end else if (push_en) begin
      we       = 1'b1;
      tos_next = tos + PW'(1);
      if (!full) begin
        count_next = count + CW'(1);
      end
    end else if (pop_en && !empty) begin
      tos_next   = tos - PW'(1);
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos         <= '0;
      count       <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= AW'(RESET_PC);
    end else begin
      tos        <= tos_next;
      count      <= count_next;
      mispredict <= miss && !flush;
      if (pop_en) begin
        redirect_pc <= actual_target;
      end
    end
  end

`ifdef JR_STACK_STATS_EN
  // Flushed pops are not counted as either outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (pop_en && !flush) begin
      if (miss) begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end else begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jr_target_stack.sv
// ---------------------------------------------------------------------------
// tb_jr_target_stack
// Self-checking bench for jr_target_stack. A list-based reference model
// (newest entry at the back, oldest dropped when more than DEPTH are held)
// supplies all expected values.
// ---------------------------------------------------------------------------
module tb_jr_target_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push_en = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic          pop_en = 1'b0;
  logic [AW-1:0] actual_target = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] pred_target;
  logic          pred_valid;
  logic          mispredict;
  logic [AW-1:0] redirect_pc;
`ifdef JR_STACK_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  jr_target_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .push_en       (push_en),
    .push_addr     (push_addr),
    .pop_en        (pop_en),
    .actual_target (actual_target),
    .flush         (flush),
    .pred_target   (pred_target),
    .pred_valid    (pred_valid),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc)
`ifdef JR_STACK_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [AW-1:0] stk[$];
  logic [AW-1:0] m_redirect = '0;
  int            m_hits = 0;
  int            m_misses = 0;

  // Values captured by drive_cycle for the calling test to compare
  logic [AW-1:0] obs_pred, exp_pred, obs_redir, exp_redir;
  logic          obs_valid, exp_valid, obs_mis, exp_mis;

  // Applies one cycle of stimulus: samples the combinational prediction
  // before the edge, advances the model, then samples registered outputs
  // one time unit after the edge.
  task automatic drive_cycle(input bit rst, input bit psh, input logic [AW-1:0] pa,
                             input bit pp, input logic [AW-1:0] at, input bit fl);
    bit m;
    reset = rst; push_en = psh; push_addr = pa;
    pop_en = pp; actual_target = at; flush = fl;
    #1;
    obs_pred  = pred_target;
    obs_valid = pred_valid;
    exp_valid = (stk.size() > 0);
    exp_pred  = exp_valid ? stk[$] : '0;
    if (rst) begin
      stk.delete();
      m_redirect = '0;
      m_hits = 0;
      m_misses = 0;
      exp_mis = 1'b0;
    end else begin
      m = pp && (!exp_valid || (exp_pred != at));
      exp_mis = m && !fl;
      if (pp) m_redirect = at;
      if (pp && !fl) begin
        if (m) m_misses++;
        else   m_hits++;
      end
      if (psh && pp && exp_valid) begin
        stk[stk.size()-1] = pa;
      end else if (psh) begin
        stk.push_back(pa);
        if (stk.size() > DEPTH) void'(stk.pop_front());
      end else if (pp && exp_valid) begin
        void'(stk.pop_back());
      end
    end
    exp_redir = m_redirect;
    @(posedge clk);
    #1;
    obs_mis   = mispredict;
    obs_redir = redirect_pc;
    reset = 1'b0; push_en = 1'b0; pop_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, '0, 0, '0, 0);
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL reset_mispredict got %0b want 0", obs_mis); else passed++;
    checks++; if (obs_redir !== 32'h0) $display("[TB] FAIL reset_redirect got %h want 00000000", obs_redir); else passed++;
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL reset_pred_valid got %0b want 0", pred_valid); else passed++;
    checks++; if (pred_target !== 32'h0) $display("[TB] FAIL reset_pred_target got %h want 00000000", pred_target); else passed++;
  endtask

  task automatic test_hit();
    drive_cycle(0, 1, 32'h0040_0010, 0, '0, 0);
    drive_cycle(0, 0, '0, 1, 32'h0040_0010, 0);
    checks++; if (obs_pred !== 32'h0040_0010) $display("[TB] FAIL hit_pred got %h want 00400010", obs_pred); else passed++;
    checks++; if (obs_valid !== 1'b1) $display("[TB] FAIL hit_valid got %0b want 1", obs_valid); else passed++;
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL hit_mispredict got %0b want 0", obs_mis); else passed++;
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL hit_empty_after got %0b want 0", pred_valid); else passed++;
  endtask

  task automatic test_empty_pop();
    drive_cycle(0, 0, '0, 1, 32'h0040_1000, 0);
    checks++; if (obs_valid !== 1'b0) $display("[TB] FAIL empty_valid got %0b want 0", obs_valid); else passed++;
    checks++; if (obs_pred !== 32'h0) $display("[TB] FAIL empty_pred got %h want 00000000", obs_pred); else passed++;
    checks++; if (obs_mis !== 1'b1) $display("[TB] FAIL empty_mispredict got %0b want 1", obs_mis); else passed++;
    checks++; if (obs_redir !== 32'h0040_1000) $display("[TB] FAIL empty_redirect got %h want 00401000", obs_redir); else passed++;
    drive_cycle(0, 0, '0, 0, '0, 0);
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL empty_pulse_width got %0b want 0", obs_mis); else passed++;
  endtask

  task automatic test_mispredict();
    drive_cycle(0, 1, 32'h0040_0004, 0, '0, 0);
    drive_cycle(0, 0, '0, 1, 32'h0040_0008, 0);
    checks++; if (obs_mis !== 1'b1) $display("[TB] FAIL mis_mispredict got %0b want 1", obs_mis); else passed++;
    checks++; if (obs_redir !== 32'h0040_0008) $display("[TB] FAIL mis_redirect got %h want 00400008", obs_redir); else passed++;
  endtask

  task automatic test_wrap();
    int seen_miss = 0;
    for (int i = 0; i < DEPTH + 2; i++) drive_cycle(0, 1, 32'h100 + 32'(4 * i), 0, '0, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_cycle(0, 0, '0, 1, 32'h100 + 32'(4 * (DEPTH + 1 - i)), 0);
      checks++; if (obs_pred !== exp_pred) $display("[TB] FAIL wrap_pred[%0d] got %h want %h", i, obs_pred, exp_pred); else passed++;
      checks++; if (obs_mis !== exp_mis) $display("[TB] FAIL wrap_mis[%0d] got %0b want %0b", i, obs_mis, exp_mis); else passed++;
      if (obs_mis) seen_miss++;
    end
    checks++; if (seen_miss != 2) $display("[TB] FAIL wrap_miss_total got %0d want 2", seen_miss); else passed++;
  endtask

  task automatic test_push_pop();
    drive_cycle(0, 1, 32'hA0, 0, '0, 0);
    drive_cycle(0, 1, 32'hB0, 1, 32'hA0, 0);
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL pushpop_mis got %0b want 0", obs_mis); else passed++;
    drive_cycle(0, 0, '0, 1, 32'hB0, 0);
    checks++; if (obs_pred !== 32'hB0) $display("[TB] FAIL pushpop_next_pred got %h want 000000b0", obs_pred); else passed++;
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL pushpop_next_mis got %0b want 0", obs_mis); else passed++;
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL pushpop_count got valid %0b want 0", pred_valid); else passed++;
  endtask

  task automatic test_flush();
    drive_cycle(0, 0, '0, 1, 32'h0000_0BAD, 1);
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL flush_mis got %0b want 0", obs_mis); else passed++;
    checks++; if (obs_redir !== 32'h0000_0BAD) $display("[TB] FAIL flush_redirect got %h want 00000bad", obs_redir); else passed++;
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, 0, '0, 1, 32'h1234, 0);
    checks++; if (obs_mis !== 1'b1) $display("[TB] FAIL rstmid_pre_mis got %0b want 1", obs_mis); else passed++;
    drive_cycle(1, 1, 32'h55, 1, 32'h66, 0);
    checks++; if (obs_mis !== 1'b0) $display("[TB] FAIL rstmid_mis got %0b want 0", obs_mis); else passed++;
    checks++; if (pred_valid !== 1'b0) $display("[TB] FAIL rstmid_valid got %0b want 0", pred_valid); else passed++;
    checks++; if (obs_redir !== 32'h0) $display("[TB] FAIL rstmid_redirect got %h want 00000000", obs_redir); else passed++;
  endtask

  task automatic test_random();
    bit rst, psh, pp, fl;
    logic [AW-1:0] pa, at;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      psh = ($urandom_range(0, 9) < 4);
      pp  = ($urandom_range(0, 9) < 4);
      fl  = ($urandom_range(0, 9) == 0);
      pa  = $urandom;
      at  = (stk.size() > 0 && $urandom_range(0, 3) != 0) ? stk[$] : $urandom;
      drive_cycle(rst, psh, pa, pp, at, fl);
      if (!rst) begin
        checks++; if (obs_valid !== exp_valid) $display("[TB] FAIL rand_valid[%0d] got %0b want %0b", i, obs_valid, exp_valid); else passed++;
        checks++; if (obs_pred !== exp_pred) $display("[TB] FAIL rand_pred[%0d] got %h want %h", i, obs_pred, exp_pred); else passed++;
      end
      checks++; if (obs_mis !== exp_mis) $display("[TB] FAIL rand_mis[%0d] got %0b want %0b", i, obs_mis, exp_mis); else passed++;
      checks++; if (obs_redir !== exp_redir) $display("[TB] FAIL rand_redirect[%0d] got %h want %h", i, obs_redir, exp_redir); else passed++;
    end
  endtask

`ifdef JR_STACK_STATS_EN
  task automatic test_stats();
    checks++; if (hit_count !== 32'(m_hits)) $display("[TB] FAIL stats_hits got %0d want %0d", hit_count, m_hits); else passed++;
    checks++; if (miss_count !== 32'(m_misses)) $display("[TB] FAIL stats_misses got %0d want %0d", miss_count, m_misses); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_hit();
    test_empty_pop();
    test_mispredict();
    test_reset();
    test_wrap();
    test_push_pop();
    test_flush();
`ifdef JR_STACK_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    test_random();
`ifdef JR_STACK_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
